pe_mx: RTL and testbench
========================

// Module: pe_mx
// PURPOSE
// - Next-gen systolic PE for the RAVEN array, parametrised in fixed-point format.
// - GEMM mode: registered systolic MAC with valid pipeline.
// - Unary modes (div/exp/log): self-contained multi-term Horner loop, acc = sat(acc)*v + c_k.
// - Coefficients stream in on wc_i; x/wc/var always forwarded to neighbour PEs.
// PARAMETERS
// - INT_BW    5   integer bits of the Q(INT.FRA) operand format.
// - FRA_BW    10  fraction bits of the operand format; acc fraction = 2*FRA_BW.
// - MUL_BW    16  operand width; must equal 1+INT_BW+FRA_BW.
// - ACC_BW    32  accumulator/output width; must be >= 2*MUL_BW.
// - ITER_MAX  8   max Horner terms per unary op.
// - CNT_BW    $clog2(ITER_MAX+1)  width of the term counter / n_terms_i.
// PORTS
// - clk        in   1       clock.
// - rst_n      in   1       reset, asynchronous, active-low.
// - mode_i     in   2       00 gemm, 01 div, 10 exp, 11 log; sampled at start_i.
// - start_i    in   1       begin unary op; honoured only in IDLE with mode_i!=00.
// - n_terms_i  in   CNT_BW  Horner term count 1..ITER_MAX, sampled with start_i.
// - valid_i    in   1       qualifies x_i/wc_i (gemm) or coefficient wc_i (ITER).
// - x_i        in   MUL_BW  signed activation.
// - wc_i       in   MUL_BW  signed weight / Horner coefficient.
// - var_i      in   MUL_BW  signed unary variable v, sampled at start_i.
// - o_i        in   ACC_BW  signed partial sum from upstream PE.
// - x_o, wc_o, var_o  out  MUL_BW  registered copies of x_i, wc_i, var_i; updated every cycle.
// - o_o        out  ACC_BW  signed result register.
// - valid_o    out  1       o_o valid: gemm result or unary completion.
// - busy_o     out  1       high in LOAD/ITER/DONE.
// - done_o     out  1       one-cycle pulse in DONE.
// BEHAVIOUR
// - Reset: all registers, outputs, counter = 0; state IDLE.
// - Mid-op reset aborts the op; no done_o is issued.
// - GEMM (IDLE, mode_i==00):
//   - edge t: wreg<=wc_i, ireg<=x_i, v1<=valid_i.
//   - edge t+1: o_o<=sext(wreg*ireg)+o_i, where o_i is presented in cycle t+1; valid_o<=v1.
//   - Latency 2 edges from x/wc; o_o holds when v1=0.
// - FSM IDLE->LOAD: on start_i & mode_i!=00 & n_terms_i!=0.
//   - Latch mode, vreg<=var_i, acc<=sext(wc_i)<<<FRA_BW (c0), cnt<=n_terms_i-1.
//   - start_i with n_terms_i==0 or mode_i==00 is ignored.
// - LOAD->ITER if cnt!=0, else LOAD->DONE.
// - ITER: each cycle with valid_i=1: acc<=narrow(acc)*vreg + (sext(wc_i)<<<FRA_BW), cnt--.
//   - Go to DONE after the update in which cnt hits 0.
//   - valid_i=0 stalls the loop; acc and cnt hold.
// - DONE (1 cycle): o_o<=acc, valid_o=1, done_o=1; then IDLE.
// - narrow(a): a[FRA_BW+MUL_BW-1:FRA_BW].
//   - Saturate to 0x7FFF..(MUL max) if a > 2^(MUL_BW+FRA_BW-1)-1.
//   - Saturate to MUL min if a < -2^(MUL_BW+FRA_BW-1).
// - start_i while busy_o=1 is ignored; mode_i changes mid-op are ignored (latched copy used).
// - GEMM datapath is frozen while busy_o=1; valid_o=0 outside gemm result and DONE.
// - Forwarding regs (x_o, wc_o, var_o) update every cycle regardless of mode/state.
// CONFIGURATION
// - PE_ACC_SAT_EN defined: every ACC_BW add (gemm and Horner) saturates to [0x80000000, 0x7FFFFFFF].
// - PE_ACC_SAT_EN undefined: two's-complement wrap modulo 2^ACC_BW.
// - narrow() saturation is always present.
// TESTING
// - T1 gemm: wc=0x0400, x=0x0800, valid=1 at t; o_i=0x00100000 at t+1.
//   -> o_o=0x00300000, valid_o=1 after edge t+1.
// - T2 Horner: mode=10, var=0x0800, n_terms=3, c0=c1=c2=0x0400, c1/c2 on consecutive valid cycles.
//   -> done_o once, o_o=0x00700000 (7.0).
// - T3 narrow sat: var=0x7FFF, n_terms=3, coefs all 0x7FFF.
//   -> 2nd step uses narrow=0x7FFF; o_o=0x41FEFC01.
// - T4 gemm overflow: wc=x=0x7FFF, o_i=0x7FFFFFFF.
//   -> o_o=0xBFFF0000 without PE_ACC_SAT_EN; 0x7FFFFFFF with it.
// - T5 stall/ignore: in T2, drop valid_i 3 cycles between c1 and c2, pulse start_i mid-op.
//   -> same result, done 3 cycles later, no restart.
// - T6 reset: assert rst_n=0 during ITER.
//   -> all outputs 0, IDLE, no done_o; new T2 run after reset passes.

Source files
------------

// File: rtl/pe_mx.sv
// rtl/pe_mx.sv - RAVEN systolic PE: gemm MAC plus Horner-loop unary ops; PE_ACC_SAT_EN selects saturating accumulate
module pe_mx #(
    parameter int INT_BW   = 5,
    parameter int FRA_BW   = 10,
    parameter int MUL_BW   = 16,
    parameter int ACC_BW   = 32,
    parameter int ITER_MAX = 8,
    parameter int CNT_BW   = $clog2(ITER_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              start_i,
    input  logic [CNT_BW-1:0] n_terms_i,
    input  logic              valid_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [MUL_BW-1:0] var_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [MUL_BW-1:0] x_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic [MUL_BW-1:0] var_o,
    output logic [ACC_BW-1:0] o_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    if ((MUL_BW != 1 + INT_BW + FRA_BW) || (ACC_BW < 2 * MUL_BW)) begin : g_cfg_err
        $error("pe_mx: inconsistent fixed-point parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_GEMM = 2'b00;

    state_t              state_q, state_d;
    logic [MUL_BW-1:0]   wreg_q, wreg_d;
    logic [MUL_BW-1:0]   ireg_q, ireg_d;
    logic                v1_q, v1_d;
    logic [MUL_BW-1:0]   vreg_q, vreg_d;
    logic [ACC_BW-1:0]   acc_q, acc_d;
    logic [CNT_BW-1:0]   cnt_q, cnt_d;
    logic [ACC_BW-1:0]   o_q, o_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [MUL_BW-1:0]   x_fwd_q, x_fwd_d;
    logic [MUL_BW-1:0]   wc_fwd_q, wc_fwd_d;
    logic [MUL_BW-1:0]   var_fwd_q, var_fwd_d;

    logic                gemm_en;
    logic [ACC_BW-1:0]   gemm_sum;
    logic [ACC_BW-1:0]   coef_acc;
    logic [ACC_BW-1:0]   horner_sum;

    function automatic logic [ACC_BW-1:0] acc_add(input logic [ACC_BW-1:0] a,
                                                  input logic [ACC_BW-1:0] b);
        logic [ACC_BW-1:0] s;
`ifdef PE_ACC_SAT_EN
        s = a + b;
        if ((a[ACC_BW-1] == b[ACC_BW-1]) && (s[ACC_BW-1] != a[ACC_BW-1]))
            s = {a[ACC_BW-1], {(ACC_BW-1){~a[ACC_BW-1]}}};
`else
        s = a + b;
`endif
        return s;
    endfunction

    function automatic logic [ACC_BW-1:0] sext_mul(input logic [MUL_BW-1:0] a,
                                                   input logic [MUL_BW-1:0] b);
        logic signed [ACC_BW-1:0] ae;
        logic signed [ACC_BW-1:0] be;
        ae = $signed({{(ACC_BW-MUL_BW){a[MUL_BW-1]}}, a});
        be = $signed({{(ACC_BW-MUL_BW){b[MUL_BW-1]}}, b});
        return ae * be;
    endfunction

    function automatic logic [ACC_BW-1:0] coef_ext(input logic [MUL_BW-1:0] c);
        return {{(ACC_BW-MUL_BW-FRA_BW){c[MUL_BW-1]}}, c, {FRA_BW{1'b0}}};
    endfunction

    // Argument is acc without its low FRA_BW bits; in range when all bits above the
    // MUL_BW-wide window are copies of the window's sign bit.
    function automatic logic [MUL_BW-1:0] narrow(input logic [ACC_BW-FRA_BW-1:0] a);
        logic [ACC_BW-FRA_BW-MUL_BW:0] top;
        top = a[ACC_BW-FRA_BW-1:MUL_BW-1];
        if ((top == '0) || (top == '1))
            return a[MUL_BW-1:0];
        else if (!a[ACC_BW-FRA_BW-1])
            return {1'b0, {(MUL_BW-1){1'b1}}};
        else
            return {1'b1, {(MUL_BW-1){1'b0}}};
    endfunction

    assign gemm_en    = (state_q == S_IDLE) && (mode_i == MODE_GEMM);
    assign gemm_sum   = acc_add(sext_mul(wreg_q, ireg_q), o_i);
    assign coef_acc   = coef_ext(wc_i);
    assign horner_sum = acc_add(sext_mul(narrow(acc_q[ACC_BW-1:FRA_BW]), vreg_q), coef_acc);

    always_comb begin
        state_d   = state_q;
        wreg_d    = wreg_q;
        ireg_d    = ireg_q;
        v1_d      = 1'b0;
        vreg_d    = vreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        x_fwd_d   = x_i;
        wc_fwd_d  = wc_i;
        var_fwd_d = var_i;

        // v1_q can only be set from IDLE, so stage two never collides with a DONE entry.
        if (gemm_en) begin
            wreg_d = wc_i;
            ireg_d = x_i;
            v1_d   = valid_i;
        end
        if (v1_q) begin
            o_d     = gemm_sum;
            valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && (mode_i != MODE_GEMM) && (n_terms_i != '0)) begin
                    vreg_d  = var_i;
                    acc_d   = coef_acc;
                    cnt_d   = n_terms_i - CNT_BW'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q != '0) ? S_ITER : S_DONE;
            end
            S_ITER: begin
                if (valid_i) begin
                    acc_d = horner_sum;
                    cnt_d = cnt_q - CNT_BW'(1);
                    if (cnt_q == CNT_BW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result registers load on entry so o_o/valid_o/done_o are all visible during DONE.
        if (state_d == S_DONE) begin
            o_d     = acc_d;
            valid_d = 1'b1;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wreg_q    <= '0;
            ireg_q    <= '0;
            v1_q      <= 1'b0;
            vreg_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            x_fwd_q   <= '0;
            wc_fwd_q  <= '0;
            var_fwd_q <= '0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            ireg_q    <= ireg_d;
            v1_q      <= v1_d;
            vreg_q    <= vreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            x_fwd_q   <= x_fwd_d;
            wc_fwd_q  <= wc_fwd_d;
            var_fwd_q <= var_fwd_d;
        end
    end

    assign x_o     = x_fwd_q;
    assign wc_o    = wc_fwd_q;
    assign var_o   = var_fwd_q;
    assign o_o     = o_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_mx.sv
// tb/tb_pe_mx.sv - self-checking bench for pe_mx against a cycle-indexed behavioural model
module tb_pe_mx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_i = '0;
    logic        start_i = 1'b0;
    logic [3:0]  n_terms_i = '0;
    logic        valid_i = 1'b0;
    logic [15:0] x_i = '0;
    logic [15:0] wc_i = '0;
    logic [15:0] var_i = '0;
    logic [31:0] o_i = '0;
    logic [15:0] x_o, wc_o, var_o;
    logic [31:0] o_o;
    logic        valid_o, busy_o, done_o;

    pe_mx dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .start_i(start_i),
        .n_terms_i(n_terms_i), .valid_i(valid_i), .x_i(x_i), .wc_i(wc_i),
        .var_i(var_i), .o_i(o_i), .x_o(x_o), .wc_o(wc_o), .var_o(var_o),
        .o_o(o_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected forwarded values: whatever was on the inputs at the last edge.
    logic [15:0] fx = '0, fw = '0, fv = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx <= '0; fw <= '0; fv <= '0;
        end else begin
            fx <= x_i; fw <= wc_i; fv <= var_i;
        end
    end

    logic [31:0] exp_o [int];
    bit          exp_d [int];
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [31:0] model_o = '0;
    logic [15:0] coef [8];
    logic [31:0] r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic longint sx16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx32(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] m_add(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef PE_ACC_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    function automatic longint m_narrow(input longint a);
        if (a > (64'sd1 <<< 25) - 1) return 32767;
        if (a < -(64'sd1 <<< 25))    return -32768;
        return a >>> 10;
    endfunction

    function automatic logic [31:0] m_gemm(input logic [15:0] x, input logic [15:0] w,
                                          input logic [31:0] oi);
        return m_add(sx16(x) * sx16(w), sx32(oi));
    endfunction

    function automatic logic [31:0] m_horner(input logic [15:0] v, input int n);
        longint acc;
        acc = sx16(coef[0]) * 1024;
        for (int i = 1; i < n; i++)
            acc = sx32(m_add(m_narrow(acc) * sx16(v), sx16(coef[i]) * 1024));
        return 32'(acc);
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_o_o", o_o, 0);
            chk("rst_valid_o", valid_o, 0);
            chk("rst_done_o", done_o, 0);
            chk("rst_busy_o", busy_o, 0);
            chk("rst_fwd", {x_o, wc_o, var_o}, 0);
            model_o = '0;
        end else begin
            if (exp_o.exists(cyc)) begin
                chk("valid_o", valid_o, 1);
                chk("o_o", o_o, exp_o[cyc]);
                chk("done_o", done_o, exp_d[cyc]);
                model_o = exp_o[cyc];
                exp_o.delete(cyc);
                exp_d.delete(cyc);
            end else begin
                chk("valid_o_idle", valid_o, 0);
                chk("done_o_idle", done_o, 0);
                chk("o_o_hold", o_o, model_o);
            end
            chk("busy_o", busy_o, (cyc >= busy_lo) && (cyc <= busy_hi));
            chk("x_o", x_o, fx);
            chk("wc_o", wc_o, fw);
            chk("var_o", var_o, fv);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start_i = 1'b0; valid_i = 1'b0; mode_i = 2'b00; n_terms_i = '0;
        x_i = 16'($urandom); wc_i = 16'($urandom); var_i = 16'($urandom); o_i = $urandom;
    endtask

    task automatic gemm_op(input logic [15:0] x, input logic [15:0] w, input logic [31:0] oi,
                           output logic [31:0] res);
        step(); quiet(); x_i = x; wc_i = w; valid_i = 1'b1;
        step(); quiet(); o_i = oi;
        res = m_gemm(x, w, oi);
        exp_o[cyc + 1] = res; exp_d[cyc + 1] = 1'b0;
        step(); quiet();
    endtask

    task automatic gemm_random(input int n);
        bit     pend = 1'b0;
        longint pp = 0;
        for (int i = 0; i < n; i++) begin
            step();
            o_i = $urandom;
            if (pend) begin
                exp_o[cyc + 1] = m_add(pp, sx32(o_i)); exp_d[cyc + 1] = 1'b0;
            end
            x_i = rnd16(); wc_i = rnd16(); var_i = rnd16();
            valid_i = 1'($urandom_range(0, 1));
            mode_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            start_i = ($urandom_range(0, 5) == 0);
            n_terms_i = (mode_i != 2'b00) ? 4'd0 : 4'($urandom_range(1, 8));
            pend = valid_i && (mode_i == 2'b00);
            pp = sx16(x_i) * sx16(wc_i);
        end
        step(); quiet();
        if (pend) begin
            exp_o[cyc + 1] = m_add(pp, sx32(o_i)); exp_d[cyc + 1] = 1'b0;
        end
        step(); quiet();
    endtask

    // stall < 0: random 0..3 idle cycles before every coefficient; else that many before the last.
    task automatic run_unary(input logic [1:0] md, input logic [15:0] v, input int n,
                             input int stall, input bit mid_start, output logic [31:0] res);
        int last;
        int ns;
        res = m_horner(v, n);
        step(); quiet();
        start_i = 1'b1; mode_i = md; var_i = v; n_terms_i = 4'(n); wc_i = coef[0];
        valid_i = 1'($urandom_range(0, 1));
        busy_lo = cyc + 1; busy_hi = 1 << 30; last = cyc + 1;
        step();
        start_i = 1'b0; valid_i = 1'($urandom_range(0, 1)); wc_i = 16'($urandom);
        mode_i = 2'($urandom); var_i = 16'($urandom);
        for (int i = 1; i < n; i++) begin
            ns = (stall < 0) ? $urandom_range(0, 3) : ((i == n - 1) ? stall : 0);
            for (int j = 0; j < ns; j++) begin
                step();
                valid_i = 1'b0; wc_i = 16'($urandom); mode_i = 2'($urandom);
                start_i = mid_start; n_terms_i = 4'($urandom_range(1, 8)); var_i = 16'($urandom);
            end
            step();
            start_i = 1'b0; valid_i = 1'b1; wc_i = coef[i]; mode_i = 2'($urandom);
            last = cyc;
        end
        exp_o[last + 1] = res; exp_d[last + 1] = 1'b1; busy_hi = last + 1;
        step();
        start_i = 1'($urandom_range(0, 1)); mode_i = 2'($urandom_range(1, 3)); n_terms_i = 4'd1;
        valid_i = 1'($urandom_range(0, 1)); wc_i = 16'($urandom);
        step(); quiet();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        quiet();

        gemm_op(16'h0400, 16'h0800, 32'h0010_0000, r);
        chk("t1_model", r, 32'h0030_0000);
        gemm_op(16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, r);
`ifdef PE_ACC_SAT_EN
        chk("t4_model", r, 32'h7FFF_FFFF);
`else
        chk("t4_model", r, 32'hBFFF_0000);
`endif

        for (int i = 0; i < 8; i++) coef[i] = 16'h0400;
        run_unary(2'b10, 16'h0800, 3, 0, 1'b0, r);
        chk("t2_model", r, 32'h0070_0000);
        run_unary(2'b10, 16'h0800, 3, 3, 1'b1, r);
        chk("t5_model", r, 32'h0070_0000);

        for (int i = 0; i < 8; i++) coef[i] = 16'h7FFF;
        run_unary(2'b01, 16'h7FFF, 3, 0, 1'b0, r);
        chk("t3_model", r, 32'h41FE_FC01);

        // T6: abort during ITER with an asynchronous reset.
        for (int i = 0; i < 8; i++) coef[i] = 16'h0400;
        step(); quiet();
        start_i = 1'b1; mode_i = 2'b10; var_i = 16'h0800; n_terms_i = 4'd3; wc_i = coef[0];
        busy_lo = cyc + 1; busy_hi = 1 << 30;
        step(); start_i = 1'b0; valid_i = 1'b0;
        step(); valid_i = 1'b1; wc_i = coef[1];
        step(); valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_o_o", o_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_fwd", {x_o, wc_o, var_o}, 0);
        exp_o.delete(); exp_d.delete(); busy_lo = 1; busy_hi = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        quiet();
        run_unary(2'b10, 16'h0800, 3, 0, 1'b0, r);
        chk("t6_rerun_model", r, 32'h0070_0000);

        for (int i = 0; i < 8; i++) coef[i] = rnd16();
        run_unary(2'b11, rnd16(), 1, -1, 1'b1, r);
        for (int i = 0; i < 8; i++) coef[i] = rnd16();
        run_unary(2'b01, rnd16(), 8, -1, 1'b1, r);

        for (int k = 0; k < 30; k++) begin
            gemm_random($urandom_range(5, 20));
            for (int i = 0; i < 8; i++) coef[i] = rnd16();
            run_unary(2'($urandom_range(1, 3)), rnd16(), $urandom_range(1, 8), -1,
                      1'($urandom_range(0, 1)), r);
        end

        repeat (4) begin step(); quiet(); end
        chk("pending_events", exp_o.num(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
